wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Shares one Wishbone classic slave (the clock-generator/serializer config slave) between NUM_M Wishbone masters.
- Round-robin arbitration; grant is held for the whole CYC bus cycle.
- Routes the slave's ACK and read data back to the granted master only.
- Sits between the CPU, test or sequencer masters and the config slave, in the CLK_I domain.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- ADR_W, 32, address width.
- DAT_W, 32, data width.
- TIMEOUT_CYC, 64, cycles allowed for the slave to ACK (used only with the optional feature).

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous active-high reset.
- M_CYC_I  in  NUM_M  per-master cycle request.
- M_STB_I  in  NUM_M  per-master strobe.
- M_WE_I  in  NUM_M  per-master write enable.
- M_ADR_I  in  NUM_M*ADR_W  packed per-master address; master i at bits [i*ADR_W +: ADR_W].
- M_DAT_I  in  NUM_M*DAT_W  packed per-master write data.
- M_ACK_O  out  NUM_M  per-master acknowledge.
- M_DAT_O  out  DAT_W  read data, broadcast to all masters; valid only with the matching M_ACK_O.
- S_CYC_O  out  1  slave cycle.
- S_STB_O  out  1  slave strobe.
- S_WE_O  out  1  slave write enable.
- S_ADR_O  out  ADR_W  slave address.
- S_DAT_O  out  DAT_W  slave write data.
- S_ACK_I  in  1  slave acknowledge.
- S_DAT_I  in  DAT_W  slave read data.
- GNT_O  out  NUM_M  one-hot registered grant, for debug and monitors.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (CLK_I, RST_I).
- Reset values:
  - GNT_O=0, round-robin pointer last=NUM_M-1, state=IDLE.
  - All S_* outputs 0, all M_ACK_O 0, M_DAT_O 0.
- FSM states are IDLE, BUSY and PARK.
  - IDLE: if any M_CYC_I bit is set, pick the first requester scanning from (last+1) mod NUM_M upward with wrap. Register GNT_O and go to BUSY. One-cycle arbitration latency: S_CYC_O rises the cycle after M_CYC_I is first sampled.
  - BUSY:
    - S_CYC_O, S_STB_O, S_WE_O, S_ADR_O and S_DAT_O are combinationally muxed from the granted master.
    - M_ACK_O[g] = S_ACK_I, and other ACK bits are 0. M_DAT_O = S_DAT_I.
    - When granted M_CYC_I[g] falls, set last=g and go to PARK.
  - PARK: one idle cycle with all S_* at 0, so the slave sees CYC low between owners. Then go to IDLE.
- Outside BUSY, all S_* outputs are 0 and all M_ACK_O are 0.
- Grant is never revoked while the granted CYC stays high. Multiple STB/ACK beats in one CYC are allowed (block transfer).
- Simultaneous requests: the rotating priority guarantees each requester is served within NUM_M grants.
- Masters must hold CYC until granted. A master that drops CYC before grant simply loses its request. No queueing.
- Granted master drops CYC mid-transfer before ACK: the slave cycle is aborted the same cycle (S_CYC_O follows the mux). Go to PARK.
- An S_ACK_I arriving while not in BUSY is ignored.
- RST_I asserted at any state: next edge applies reset values. No transfer is completed or reported.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - Adds output M_ERR_O [NUM_M].
  - In BUSY, a counter increments each cycle that S_STB_O=1 and S_ACK_I=0, and clears on ACK.
  - When the count reaches TIMEOUT_CYC, pulse M_ERR_O[g] for 1 cycle, force S_CYC_O/S_STB_O low, set last=g and go to PARK regardless of M_CYC_I[g].
  - The master must drop CYC after ERR. It is not regranted while its CYC stays high from the aborted cycle; it must see CYC low for at least one cycle first.
- Undefined: no counter, no M_ERR_O port. A hung slave holds the bus indefinitely.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, PARK} arb_state_t;
  - localparams for default ADR_W/DAT_W;
  - function clog2-based pointer width helper.
- Sub-module rr_pick: combinational rotating-priority picker; inputs req[NUM_M] and last ptr, outputs one-hot gnt and index.

Test Plan:
- Single master: after reset, M0 writes ADR=0, DAT=32'h0003_0201, WE=1. Expect S_CYC_O 1 cycle after M_CYC_I[0]; S_DAT_O=32'h0003_0201; M_ACK_O[0] mirrors S_ACK_I; M_ACK_O[1]=0.
- Contention: M0 and M1 raise CYC on the same edge after reset (last=1). Expect M0 granted first. Then PARK with 1 cycle of S_CYC_O=0. Then M1 granted and its DAT 32'h0000_00AA reaches S_DAT_O.
- Fairness: with NUM_M=3 and all CYC held continuously, each doing 1 write then dropping CYC 1 cycle, expect grant order 0,1,2,0,1,2 across 6 transfers.
- Read path: M1 reads with WE=0 while the slave returns 32'hDEAD_BEEF with ACK. Expect M_DAT_O=32'hDEAD_BEEF and M_ACK_O=3'b010 in that cycle only.
- Reset mid-transfer: assert RST_I while BUSY with STB high. Next edge all S_*=0 and GNT_O=0. The next request from M2 (NUM_M=3) is granted first since last resets to 2 and the scan starts at 0, giving M0>M1>M2 (M2 granted when alone).
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8: slave never ACKs. Expect M_ERR_O[g] pulse exactly 8 cycles after S_STB_O rises, S_CYC_O low the next cycle, and the other pending master granted after PARK.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Optional timeout/error feature is enabled with WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        PARK
    } arb_state_t;

    localparam int DEF_ADR_W = 32;
    localparam int DEF_DAT_W = 32;

    // Width of a master index; never less than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first requester above 'last'
// (with wrap) wins and is returned both one-hot and as an index.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int PW    = ptr_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PW-1:0]    last,
    output logic [NUM_M-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    always_comb begin
        logic [PW-1:0] cand;
        // NOTE: every output gets a default before the loop so no path through the block leaves one unassigned (which would infer a latch).
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = PW'((int'(last) + k) % NUM_M);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM_M masters.
// Define WB_ARB_TIMEOUT_EN to add the ACK timeout and the M_ERR_O port.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int ADR_W = DEF_ADR_W,
    parameter int DAT_W = DEF_DAT_W
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [NUM_M-1:0]       M_CYC_I,
    input  logic [NUM_M-1:0]       M_STB_I,
    input  logic [NUM_M-1:0]       M_WE_I,
    input  logic [NUM_M*ADR_W-1:0] M_ADR_I,
    input  logic [NUM_M*DAT_W-1:0] M_DAT_I,
    output logic [NUM_M-1:0]       M_ACK_O,
    output logic [DAT_W-1:0]       M_DAT_O,
    output logic                   S_CYC_O,
    output logic                   S_STB_O,
    output logic                   S_WE_O,
    output logic [ADR_W-1:0]       S_ADR_O,
    output logic [DAT_W-1:0]       S_DAT_O,
    input  logic                   S_ACK_I,
    input  logic [DAT_W-1:0]       S_DAT_I,
    output logic [NUM_M-1:0]       GNT_O
`ifdef WB_ARB_TIMEOUT_EN
    ,
    output logic [NUM_M-1:0]       M_ERR_O
`endif
);

    localparam int PW = ptr_w(NUM_M);

    arb_state_t       state_q, state_n;
    logic [NUM_M-1:0] gnt_q, gnt_n;
    logic [PW-1:0]    idx_q, idx_n;
    logic [PW-1:0]    last_q, last_n;
    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             timeout_hit;
    logic             live;

    rr_pick #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    // A master whose cycle timed out stays masked until it has released CYC.
    logic [NUM_M-1:0] block_q;

    assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC));
    assign req         = M_CYC_I & ~block_q;
    assign M_ERR_O     = timeout_hit ? gnt_q : '0;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q   <= '0;
            block_q <= '0;
        end else begin
            block_q <= (block_q & M_CYC_I) | (timeout_hit ? gnt_q : '0);
            if (state_q != BUSY || S_ACK_I) begin
                cnt_q <= '0;
            end else if (S_STB_O) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign req         = M_CYC_I;
`endif

    // The granted master drives the slave only while BUSY and not timed out.
    assign live  = (state_q == BUSY) && !timeout_hit;
    assign GNT_O = gnt_q;

    always_comb begin
        S_CYC_O = 1'b0;
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        M_ACK_O = '0;
        M_DAT_O = '0;
        if (live) begin
            S_CYC_O          = M_CYC_I[idx_q];
            S_STB_O          = M_STB_I[idx_q];
            S_WE_O           = M_WE_I[idx_q];
            S_ADR_O          = M_ADR_I[idx_q*ADR_W +: ADR_W];
            S_DAT_O          = M_DAT_I[idx_q*DAT_W +: DAT_W];
            M_ACK_O[idx_q]   = S_ACK_I;
            M_DAT_O          = S_DAT_I;
        end
    end

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        idx_n   = idx_q;
        last_n  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n   = pick_gnt;
                    idx_n   = pick_idx;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!M_CYC_I[idx_q] || timeout_hit) begin
                    last_n  = idx_q;
                    gnt_n   = '0;
                    state_n = PARK;
                end
            end
            PARK:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (RST_I) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= PW'(NUM_M - 1);
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            idx_q   <= idx_n;
            last_q  <= last_n;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter with three masters; covers the timeout
// path as well when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;

    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N-1:0]    m_ack;
    logic [DW-1:0]   m_rdat;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic            s_ack;
    logic [DW-1:0]   s_rdat;
    logic [N-1:0]    gnt;
`ifdef WB_ARB_TIMEOUT_EN
    logic [N-1:0]    m_err;
`endif

    int total = 0;
    int bad = 0;
    int model_last = N - 1;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_M       (N),
        .ADR_W       (AW),
        .DAT_W       (DW)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst),
        .M_CYC_I (m_cyc),
        .M_STB_I (m_stb),
        .M_WE_I  (m_we),
        .M_ADR_I (m_adr),
        .M_DAT_I (m_dat),
        .M_ACK_O (m_ack),
        .M_DAT_O (m_rdat),
        .S_CYC_O (s_cyc),
        .S_STB_O (s_stb),
        .S_WE_O  (s_we),
        .S_ADR_O (s_adr),
        .S_DAT_O (s_wdat),
        .S_ACK_I (s_ack),
        .S_DAT_I (s_rdat),
`ifdef WB_ARB_TIMEOUT_EN
        .M_ERR_O (m_err),
`endif
        .GNT_O   (gnt)
    );

    // Reference rule: first requester strictly after 'last', wrapping around.
    function automatic int model_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        m_we[m]  = we;
        m_adr[m*AW +: AW] = a;
        m_dat[m*DW +: DW] = d;
    endtask

    task automatic drop_m(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // Waits (bounded) for the slave cycle to open; leaves time at that negedge.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (s_cyc === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Acks the current beat, releases the master and steps through PARK to IDLE.
    task automatic finish_m(input int m);
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        drop_m(m);
        tick();
        tick();
        model_last = m;
    endtask

    task automatic test_reset();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        s_ack = 1'b0; s_rdat = '0;
        apply_reset();
        @(negedge clk);
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want %b", gnt, 3'b000); end
        total++; if ({s_cyc, s_stb, s_we, s_adr, s_wdat} !== '0) begin bad++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h dat=%h want all zero", s_cyc, s_stb, s_adr, s_wdat); end
        total++; if (m_ack !== '0 || m_rdat !== '0) begin bad++; $display("FAIL reset_master: got ack=%b dat=%h want zero", m_ack, m_rdat); end
    endtask

    task automatic test_single();
        tick();
        set_m(0, 1'b1, 32'h0, 32'h0003_0201);
        @(negedge clk);
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL single_latency: got s_cyc=%b want 0", s_cyc); end
        @(negedge clk);
        total++; if (s_cyc !== 1'b1 || gnt !== 3'b001) begin bad++; $display("FAIL single_grant: got s_cyc=%b gnt=%b want 1 001", s_cyc, gnt); end
        total++; if (s_wdat !== 32'h0003_0201 || s_we !== 1'b1 || s_adr !== 32'h0) begin bad++; $display("FAIL single_mux: got dat=%h we=%b adr=%h want 00030201 1 0", s_wdat, s_we, s_adr); end
        total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL single_noack: got %b want 000", m_ack); end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        total++; if (m_ack !== 3'b001) begin bad++; $display("FAIL single_ack: got %b want 001", m_ack); end
        tick();
        s_ack = 1'b0;
        drop_m(0);
        @(negedge clk);
        total++; if (s_cyc !== 1'b0) begin bad++; $display("FAIL single_release: got s_cyc=%b want 0", s_cyc); end
        tick();
        @(negedge clk);
        total++; if (gnt !== 3'b000 || s_cyc !== 1'b0) begin bad++; $display("FAIL single_park: got gnt=%b s_cyc=%b want 000 0", gnt, s_cyc); end
        tick();
        model_last = 0;
    endtask

    task automatic test_contention();
        bit ok;
        int g;
        apply_reset();
        set_m(0, 1'b1, 32'h10, 32'h0000_0011);
        set_m(1, 1'b1, 32'h20, 32'h0000_00AA);
        wait_grant(ok);
        g = model_pick(m_cyc, model_last);
        total++; if (!ok || gnt !== onehot(g)) begin bad++; $display("FAIL cont_first: got ok=%0d gnt=%b want %b", ok, gnt, onehot(g)); end
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        drop_m(g);
        model_last = g;
        tick();
        @(negedge clk);
        total++; if (s_cyc !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL cont_park: got s_cyc=%b gnt=%b want 0 000", s_cyc, gnt); end
        wait_grant(ok);
        g = model_pick(m_cyc, model_last);
        total++; if (!ok || gnt !== onehot(g)) begin bad++; $display("FAIL cont_second: got ok=%0d gnt=%b want %b", ok, gnt, onehot(g)); end
        total++; if (s_wdat !== m_dat[g*DW +: DW]) begin bad++; $display("FAIL cont_data: got %h want %h", s_wdat, m_dat[g*DW +: DW]); end
        finish_m(g);
    endtask

    task automatic test_fairness();
        bit ok;
        int g;
        int d;
        for (int m = 0; m < N; m++) set_m(m, 1'b1, $urandom, $urandom);
        for (int n = 0; n < 9; n++) begin
            wait_grant(ok);
            g = model_pick(m_cyc, model_last);
            total++; if (!ok || gnt !== onehot(g)) begin bad++; $display("FAIL fair_gnt%0d: got ok=%0d gnt=%b want %b", n, ok, gnt, onehot(g)); end
            total++; if (s_wdat !== m_dat[g*DW +: DW] || s_adr !== m_adr[g*AW +: AW]) begin bad++; $display("FAIL fair_mux%0d: got adr=%h dat=%h want %h %h", n, s_adr, s_wdat, m_adr[g*AW +: AW], m_dat[g*DW +: DW]); end
            d = $urandom_range(0, 3);
            repeat (d) begin
                tick();
                @(negedge clk);
                total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL fair_wait%0d: got ack=%b want 000", n, m_ack); end
            end
            tick();
            s_ack = 1'b1;
            s_rdat = $urandom;
            @(negedge clk);
            total++; if (m_ack !== onehot(g)) begin bad++; $display("FAIL fair_ack%0d: got %b want %b", n, m_ack, onehot(g)); end
            tick();
            s_ack = 1'b0;
            drop_m(g);
            model_last = g;
            tick();
            if (n < 8) set_m(g, 1'b1, $urandom, $urandom);
            else begin
                m_cyc = '0;
                m_stb = '0;
            end
        end
        tick();
    endtask

    task automatic test_read();
        bit ok;
        int g;
        set_m(1, 1'b0, $urandom, 32'h0);
        wait_grant(ok);
        g = model_pick(m_cyc, model_last);
        total++; if (!ok || gnt !== onehot(g) || s_we !== 1'b0) begin bad++; $display("FAIL read_gnt: got ok=%0d gnt=%b we=%b want %b 0", ok, gnt, s_we, onehot(g)); end
        tick();
        s_ack = 1'b1;
        s_rdat = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (m_rdat !== 32'hDEAD_BEEF || m_ack !== 3'b010) begin bad++; $display("FAIL read_data: got dat=%h ack=%b want deadbeef 010", m_rdat, m_ack); end
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        total++; if (m_ack !== 3'b000) begin bad++; $display("FAIL read_ack_once: got %b want 000", m_ack); end
        tick();
        drop_m(1);
        model_last = 1;
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        total++; if (m_ack !== 3'b000 || s_cyc !== 1'b0) begin bad++; $display("FAIL read_stray_ack: got ack=%b s_cyc=%b want 000 0", m_ack, s_cyc); end
        tick();
        s_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g;
        set_m(0, 1'b1, $urandom, $urandom);
        wait_grant(ok);
        total++; if (!ok || s_stb !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got ok=%0d s_stb=%b want 1", ok, s_stb); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = N - 1;
        drop_m(0);
        set_m(2, 1'b1, $urandom, $urandom);
        @(negedge clk);
        total++; if ({s_cyc, s_stb, s_we, s_adr, s_wdat} !== '0 || gnt !== '0 || m_ack !== '0) begin bad++; $display("FAIL rstmid_clear: got cyc=%b stb=%b gnt=%b ack=%b want all zero", s_cyc, s_stb, gnt, m_ack); end
        wait_grant(ok);
        g = model_pick(m_cyc, model_last);
        total++; if (!ok || gnt !== onehot(g)) begin bad++; $display("FAIL rstmid_regrant: got ok=%0d gnt=%b want %b", ok, gnt, onehot(g)); end
        finish_m(g);
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int g;
        int o;
        set_m(0, 1'b1, $urandom, $urandom);
        set_m(1, 1'b1, $urandom, $urandom);
        wait_grant(ok);
        g = model_pick(m_cyc, model_last);
        total++; if (!ok || gnt !== onehot(g) || m_err !== '0) begin bad++; $display("FAIL to_gnt: got ok=%0d gnt=%b err=%b want %b 000", ok, gnt, m_err, onehot(g)); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (m_err !== ((k == 8) ? onehot(g) : 3'b000)) begin
                bad++;
                $display("FAIL to_err_c%0d: got %b want %b", k, m_err, (k == 8) ? onehot(g) : 3'b000);
            end
        end
        @(negedge clk);
        total++; if (s_cyc !== 1'b0 || m_err !== 3'b000) begin bad++; $display("FAIL to_abort: got s_cyc=%b err=%b want 0 000", s_cyc, m_err); end
        model_last = g;
        tick();
        wait_grant(ok);
        o = model_pick(m_cyc & ~onehot(g), model_last);
        total++; if (!ok || gnt !== onehot(o)) begin bad++; $display("FAIL to_other: got ok=%0d gnt=%b want %b", ok, gnt, onehot(o)); end
        finish_m(o);
        repeat (4) @(negedge clk);
        total++; if (s_cyc !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL to_blocked: got s_cyc=%b gnt=%b want 0 000", s_cyc, gnt); end
        tick();
        drop_m(g);
        tick();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_read();
        test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
